// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode / funct field values of the supported instructions
//   - alu_control encodings driven to the datapath ALU
//   - control FSM state enumeration
//   - instruction-class enumeration produced by the decoder
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_ADDI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_INVALID
  } instr_class_e;

endpackage

// File: rtl/mips_instr_decode.sv
// ---------------------------------------------------------------------------
// mips_instr_decode
// Purely combinational decode of one 32-bit MIPS word.
// Ports:
//   instruction  in  32  raw instruction word
//   instr_class  out     instruction class (CL_INVALID for unsupported words)
//   alu_control  out  2  ALU operation for the class / funct
//   alu_src_imm  out  1  ALU B operand comes from the sign-extended immediate
//   write_addr   out  5  write-back register: rd for R-type, rt otherwise
// ---------------------------------------------------------------------------
module mips_instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_e instr_class,
  output logic [1:0]   alu_control,
  output logic         alu_src_imm,
  output logic [4:0]   write_addr
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    instr_class = CL_INVALID;
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    write_addr  = instruction[20:16];

    case (opcode)
      OP_RTYPE: begin
        write_addr = instruction[15:11];
        case (funct)
          FN_ADD: begin instr_class = CL_RTYPE; alu_control = ALU_ADD; end
          FN_SUB: begin instr_class = CL_RTYPE; alu_control = ALU_SUB; end
          FN_AND: begin instr_class = CL_RTYPE; alu_control = ALU_AND; end
          FN_OR:  begin instr_class = CL_RTYPE; alu_control = ALU_OR;  end
          default: instr_class = CL_INVALID;
        endcase
      end
      OP_ADDI: begin instr_class = CL_ADDI; alu_src_imm = 1'b1; end
      OP_LW:   begin instr_class = CL_LW;   alu_src_imm = 1'b1; end
      OP_SW:   begin instr_class = CL_SW;   alu_src_imm = 1'b1; end
      OP_BEQ:  begin instr_class = CL_BEQ;  alu_control = ALU_SUB; end
      default: instr_class = CL_INVALID;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
// Multi-cycle control unit: accepts one instruction over valid/ready, latches
// its fields and steps the datapath enables through a per-class sequence
//   R/addi : IDLE->DECODE->EXECUTE->WRITEBACK->IDLE
//   lw     : IDLE->DECODE->EXECUTE->MEMORY->WRITEBACK->IDLE
//   sw     : IDLE->DECODE->EXECUTE->MEMORY->IDLE
//   beq    : IDLE->DECODE->EXECUTE->IDLE
//   invalid: IDLE->DECODE->IDLE (error pulse, no enables, no done)
// Ports:
//   clock, reset_n               clock / async active-low reset
//   instr_valid, instr_ready     instruction handshake (ready only in IDLE)
//   instruction                  32-bit word, sampled at transfer only
//   alu_zero                     ALU zero flag, sampled in EXECUTE for beq
//   rs, rt, rd, write_addr,
//   immediate, alu_control,
//   alu_src_imm                  fields latched at transfer
//   reg_write, mem_read,
//   mem_write, mem_to_reg        one-cycle datapath enables
//   branch_taken, done,
//   err_invalid_instruction      one-cycle status pulses
//   retire_count                 retired-instruction counter, present only
//                                when MIPS_CTRL_RETIRE_COUNT_EN is defined
// All outputs are registered; enables depend on state and latched class only.
// ---------------------------------------------------------------------------
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  write_addr,
  output logic [15:0] immediate,
  output logic [1:0]  alu_control,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch_taken,
  output logic        done,
  output logic        err_invalid_instruction
`ifdef MIPS_CTRL_RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  instr_class_e dec_class;
  logic [1:0]   dec_alu_control;
  logic         dec_alu_src_imm;
  logic [4:0]   dec_write_addr;

  mips_instr_decode u_decode (
    .instruction (instruction),
    .instr_class (dec_class),
    .alu_control (dec_alu_control),
    .alu_src_imm (dec_alu_src_imm),
    .write_addr  (dec_write_addr)
  );

  state_e       state_q, state_d;
  instr_class_e class_q, class_d;
  logic [4:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, write_addr_q, write_addr_d;
  logic [15:0]  immediate_q, immediate_d;
  logic [1:0]   alu_control_q, alu_control_d;
  logic         alu_src_imm_q, alu_src_imm_d;
  logic         instr_ready_q, instr_ready_d;
  logic         reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic         branch_taken_q, branch_taken_d, done_q, done_d;
  logic         err_q, err_d;

  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rd_d          = rd_q;
    write_addr_d  = write_addr_q;
    immediate_d   = immediate_q;
    alu_control_d = alu_control_q;
    alu_src_imm_d = alu_src_imm_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d       = ST_DECODE;
          class_d       = dec_class;
          rs_d          = instruction[25:21];
          rt_d          = instruction[20:16];
          rd_d          = instruction[15:11];
          write_addr_d  = dec_write_addr;
          immediate_d   = instruction[15:0];
          alu_control_d = dec_alu_control;
          alu_src_imm_d = dec_alu_src_imm;
        end
      end
      ST_DECODE:  state_d = (class_q == CL_INVALID) ? ST_IDLE : ST_EXECUTE;
      ST_EXECUTE: begin
        case (class_q)
          CL_BEQ:       state_d = ST_IDLE;
          CL_LW, CL_SW: state_d = ST_MEMORY;
          default:      state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY:    state_d = (class_q == CL_LW) ? ST_WRITEBACK : ST_IDLE;
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so that, once
    // registered, each one lines up exactly with that state's cycle.
    instr_ready_d  = (state_d == ST_IDLE);
    reg_write_d    = (state_d == ST_WRITEBACK);
    mem_to_reg_d   = (state_d == ST_WRITEBACK) && (class_d == CL_LW);
    mem_read_d     = (state_d == ST_MEMORY)    && (class_d == CL_LW);
    mem_write_d    = (state_d == ST_MEMORY)    && (class_d == CL_SW);
    err_d          = (state_d == ST_DECODE)    && (class_d == CL_INVALID);
    done_d         = (state_d == ST_WRITEBACK)
                   || ((state_d == ST_MEMORY)  && (class_d == CL_SW))
                   || ((state_d == ST_EXECUTE) && (class_d == CL_BEQ));
    // The flag is sampled during EXECUTE and shows up in the following cycle.
    branch_taken_d = (state_q == ST_EXECUTE) && (class_q == CL_BEQ) && alu_zero;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      class_q        <= CL_INVALID;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      write_addr_q   <= '0;
      immediate_q    <= '0;
      alu_control_q  <= ALU_ADD;
      alu_src_imm_q  <= 1'b0;
      instr_ready_q  <= 1'b1;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      branch_taken_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q        <= state_d;
      class_q        <= class_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      write_addr_q   <= write_addr_d;
      immediate_q    <= immediate_d;
      alu_control_q  <= alu_control_d;
      alu_src_imm_q  <= alu_src_imm_d;
      instr_ready_q  <= instr_ready_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      branch_taken_q <= branch_taken_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

`ifdef MIPS_CTRL_RETIRE_COUNT_EN
  logic [31:0] retire_count_q, retire_count_d;

  // Counts in step with done; wraps naturally at 32 bits.
  assign retire_count_d = retire_count_q + 32'(done_d);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) retire_count_q <= '0;
    else          retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

  assign instr_ready             = instr_ready_q;
  assign rs                      = rs_q;
  assign rt                      = rt_q;
  assign rd                      = rd_q;
  assign write_addr              = write_addr_q;
  assign immediate               = immediate_q;
  assign alu_control             = alu_control_q;
  assign alu_src_imm             = alu_src_imm_q;
  assign reg_write               = reg_write_q;
  assign mem_read                = mem_read_q;
  assign mem_write               = mem_write_q;
  assign mem_to_reg              = mem_to_reg_q;
  assign branch_taken            = branch_taken_q;
  assign done                    = done_q;
  assign err_invalid_instruction = err_q;

endmodule
